// File: rtl/alu_issue_pkg.sv
// Shared constants, op codes and FSM state type for the ALU command issuer.
package alu_issue_pkg;

    localparam int ALU_W = 4;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOT = 3'b101;
    localparam logic [2:0] ALU_SHL = 3'b110;
    localparam logic [2:0] ALU_SHR = 3'b111;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_t;

    // Only add/sub produce a meaningful carry/borrow.
    function automatic logic op_sets_carry(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU and response signals of the issuer. Optional rsp_zero is
// present only when ALU_ISSUE_ZFLAG_EN is defined.
interface alu_cmd_issuer_if
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = ALU_W,
    parameter int NREG   = 4
) ();
    localparam int RW = $clog2(NREG);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_load;
    logic [2:0]        cmd_op;
    logic [RW-1:0]     cmd_dst;
    logic [RW-1:0]     cmd_src_a;
    logic [RW-1:0]     cmd_src_b;
    logic [DATA_W-1:0] cmd_imm;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_sel;
    logic [DATA_W-1:0] alu_out;
    logic              alu_carry;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_carry;
`ifdef ALU_ISSUE_ZFLAG_EN
    logic              rsp_zero;
`endif
    logic              busy;

    modport slave (
        input  cmd_valid, cmd_load, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
        input  alu_out, alu_carry, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_carry,
`ifdef ALU_ISSUE_ZFLAG_EN
        output rsp_zero,
`endif
        output busy
    );

    modport master (
        output cmd_valid, cmd_load, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
        output alu_out, alu_carry, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_carry,
`ifdef ALU_ISSUE_ZFLAG_EN
        input  rsp_zero,
`endif
        input  busy
    );

endinterface

// File: rtl/alu_issue_regfile.sv
// NREG x DATA_W register file: two async read ports, one sync write port.
module alu_issue_regfile #(
    parameter int DATA_W = 4,
    parameter int NREG   = 4,
    parameter int RW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RW-1:0]     raddr_a,
    input  logic [RW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [RW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata
);
    logic [NREG-1:0][DATA_W-1:0] mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     mem <= '0;
        else if (we) mem[waddr] <= wdata;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_cmd_issuer.sv
// Sequential front-end for the 4-bit combinational ALU: IDLE -> ISSUE -> RESP.
// Optional zero flag on the response: define ALU_ISSUE_ZFLAG_EN.
module alu_cmd_issuer
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = ALU_W,
    parameter int NREG   = 4
) (
    input  logic           clk,
    input  logic           rst,
    alu_cmd_issuer_if.slave bus
);
    localparam int RW = $clog2(NREG);

    state_t            state, state_nx;
    logic [DATA_W-1:0] a_q, b_q, rd_a, rd_b, wdata, rsp_data_q;
    logic [2:0]        op_q;
    logic [RW-1:0]     dst_q, waddr;
    logic              acc, we, carry_q;

    assign acc = bus.cmd_valid && (state == ST_IDLE);

    // The response register and the register-file write share one enable/data path.
    assign we    = (acc && bus.cmd_load) || (state == ST_ISSUE);
    assign waddr = (state == ST_ISSUE) ? dst_q   : bus.cmd_dst;
    assign wdata = (state == ST_ISSUE) ? bus.alu_out : bus.cmd_imm;

    alu_issue_regfile #(.DATA_W(DATA_W), .NREG(NREG), .RW(RW)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (bus.cmd_src_a),
        .raddr_b (bus.cmd_src_b),
        .rdata_a (rd_a),
        .rdata_b (rd_b),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (acc) state_nx = bus.cmd_load ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_nx = ST_RESP;
            ST_RESP:  if (bus.rsp_ready) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            dst_q      <= '0;
            rsp_data_q <= '0;
            carry_q    <= 1'b0;
        end else begin
            if (acc && !bus.cmd_load) begin
                a_q   <= rd_a;
                b_q   <= rd_b;
                op_q  <= bus.cmd_op;
                dst_q <= bus.cmd_dst;
            end
            if (we) rsp_data_q <= wdata;
            if (state == ST_ISSUE && op_sets_carry(op_q)) carry_q <= bus.alu_carry;
        end
    end

`ifdef ALU_ISSUE_ZFLAG_EN
    logic zero_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     zero_q <= 1'b0;
        else if (we) zero_q <= (wdata == '0);
    end
    assign bus.rsp_zero = zero_q;
`endif

    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_carry = carry_q;
    assign bus.alu_a     = (state == ST_ISSUE) ? a_q  : '0;
    assign bus.alu_b     = (state == ST_ISSUE) ? b_q  : '0;
    assign bus.alu_sel   = (state == ST_ISSUE) ? op_q : 3'b000;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with a behavioural 4-bit ALU attached.
module tb_alu_cmd_issuer;
    import alu_issue_pkg::*;

    typedef struct packed {
        logic [3:0] d;
        logic       c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_cmd_issuer_if #(.DATA_W(4), .NREG(4)) bus ();

    alu_cmd_issuer #(.DATA_W(4), .NREG(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    exp_t       q[$];
    logic [3:0] mreg[4];
    logic       mcarry;
    logic [4:0] alu_r;

    // External ALU: carry is deliberately nonzero for several logic ops so a
    // flag that wrongly follows alu_carry shows up.
    function automatic logic [4:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            ALU_ADD: return {1'b0, a} + {1'b0, b};
            ALU_SUB: return {a < b, a - b};
            ALU_AND: return {1'b1, a & b};
            ALU_OR:  return {1'b1, a | b};
            ALU_XOR: return {1'b0, a ^ b};
            ALU_NOT: return {1'b1, ~a};
            ALU_SHL: return {a[3], a << 1};
            default: return {a[0], a >> 1};
        endcase
    endfunction

    always_comb begin
        alu_r         = alu_ref(bus.alu_sel, bus.alu_a, bus.alu_b);
        bus.alu_carry = alu_r[4];
        bus.alu_out   = alu_r[3:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic ld, input logic [2:0] op, input logic [1:0] dst,
                        input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] imm,
                        input bit push);
        logic [3:0] ea, eb;
        logic [4:0] r;
        @(negedge clk);
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        ea = mreg[sa];
        eb = mreg[sb];
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = ld;
        bus.cmd_op    = op;
        bus.cmd_dst   = dst;
        bus.cmd_src_a = sa;
        bus.cmd_src_b = sb;
        bus.cmd_imm   = imm;
        if (push) begin
            if (ld) begin
                mreg[dst] = imm;
                q.push_back('{d: imm, c: mcarry});
            end else begin
                r = alu_ref(op, ea, eb);
                mreg[dst] = r[3:0];
                if (op == ALU_ADD || op == ALU_SUB) mcarry = r[4];
                q.push_back('{d: r[3:0], c: mcarry});
            end
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        chk("busy_after_accept", bus.busy, 1);
        chk("cmd_ready_after_accept", bus.cmd_ready, 0);
        if (ld) begin
            chk("load_rsp_latency", bus.rsp_valid, 1);
        end else begin
            chk("issue_sel", bus.alu_sel, op);
            chk("issue_a", bus.alu_a, ea);
            chk("issue_b", bus.alu_b, eb);
            chk("issue_no_rsp", bus.rsp_valid, 0);
            if (push) begin
                @(posedge clk);
                #1;
                chk("op_rsp_latency", bus.rsp_valid, 1);
                chk("alu_idle_zero", bus.alu_a, 0);
            end
        end
    endtask

    task automatic get_rsp(input int stall, output logic [3:0] d, output logic c);
        exp_t e;
        int   n;
        n = 0;
        d = '0;
        c = 1'b0;
        while (!bus.rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rsp_valid) begin
            chk("rsp_timeout", 0, 1);
            return;
        end
        if (q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        e = q.pop_front();
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b1;
            bus.cmd_load  = 1'b1;
            bus.cmd_dst   = 2'd0;
            bus.cmd_imm   = 4'hF;
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_data", bus.rsp_data, e.d);
            chk("bp_cmd_ready", bus.cmd_ready, 0);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        d = bus.rsp_data;
        c = bus.rsp_carry;
        chk("rsp_data", bus.rsp_data, e.d);
        chk("rsp_carry", bus.rsp_carry, e.c);
`ifdef ALU_ISSUE_ZFLAG_EN
        chk("rsp_zero", bus.rsp_zero, (e.d == 4'h0));
`endif
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_done_valid", bus.rsp_valid, 0);
        chk("rsp_done_ready", bus.cmd_ready, 1);
    endtask

    initial begin
        logic [3:0] d;
        logic       c;
        bus.cmd_valid = 1'b0;
        bus.cmd_load  = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_dst   = '0;
        bus.cmd_src_a = '0;
        bus.cmd_src_b = '0;
        bus.cmd_imm   = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) mreg[i] = '0;
        mcarry = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_carry", bus.rsp_carry, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_sel", bus.alu_sel, 0);
`ifdef ALU_ISSUE_ZFLAG_EN
        chk("rst_rsp_zero", bus.rsp_zero, 0);
`endif
        rst = 1'b0;

        send(1'b1, ALU_ADD, 2'd0, 2'd0, 2'd0, 4'h9, 1'b1); get_rsp(0, d, c);
        send(1'b1, ALU_ADD, 2'd1, 2'd0, 2'd0, 4'h8, 1'b1); get_rsp(0, d, c);
        send(1'b0, ALU_ADD, 2'd2, 2'd0, 2'd1, 4'h0, 1'b1); get_rsp(0, d, c);
        chk("add_9_8_data", d, 4'h1);
        chk("add_9_8_carry", c, 1);
        send(1'b0, ALU_SUB, 2'd3, 2'd1, 2'd0, 4'h0, 1'b1); get_rsp(0, d, c);
        chk("sub_8_9_data", d, 4'hF);
        chk("sub_8_9_borrow", c, 1);
        send(1'b0, ALU_SUB, 2'd3, 2'd0, 2'd1, 4'h0, 1'b1); get_rsp(0, d, c);
        chk("sub_9_8_data", d, 4'h1);
        chk("sub_9_8_borrow", c, 0);
        send(1'b0, ALU_ADD, 2'd2, 2'd0, 2'd1, 4'h0, 1'b1); get_rsp(0, d, c);
        send(1'b0, ALU_XOR, 2'd0, 2'd0, 2'd0, 4'h0, 1'b1); get_rsp(0, d, c);
        chk("xor_data", d, 4'h0);
        chk("xor_carry_held", c, 1);
        send(1'b0, ALU_NOT, 2'd1, 2'd1, 2'd0, 4'h0, 1'b1); get_rsp(5, d, c);
        chk("not_bp_data", d, 4'h7);

        for (int i = 0; i < 12; i++) begin
            send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'b1);
            get_rsp(int'($urandom_range(0, 2)), d, c);
        end

        send(1'b1, ALU_ADD, 2'd0, 2'd0, 2'd0, 4'h9, 1'b1); get_rsp(0, d, c);
        send(1'b1, ALU_ADD, 2'd1, 2'd0, 2'd0, 4'h8, 1'b1); get_rsp(0, d, c);
        send(1'b0, ALU_ADD, 2'd2, 2'd0, 2'd1, 4'h0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_issue_valid", bus.rsp_valid, 0);
        chk("rst_issue_busy", bus.busy, 0);
        chk("rst_issue_alu_a", bus.alu_a, 0);
        for (int i = 0; i < 4; i++) mreg[i] = '0;
        mcarry = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send(1'b0, ALU_ADD, 2'd3, 2'd2, 2'd2, 4'h0, 1'b1); get_rsp(0, d, c);
        chk("post_rst_data", d, 4'h0);
        chk("post_rst_carry", c, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
